ie_gap_head: RTL and testbench
==============================

Name: ie_gap_head

Overview:
- Downstream consumer of the ie120r encoder output stream (7x7 spatial grid, 64 channel groups of 8 lanes x 32-bit).
- Performs global average pooling over the 49 spatial positions per channel and emits one pooled 512-channel vector per frame: 64 beats of 8 lanes, with a valid/ready handshake.
- Feeds the classifier/projection head.

Parameters:
- GROUPS, 64, channel groups per position (the s_chan/m_chan range).
- LANES, 8, 32-bit lanes per beat.
- DW, 32, lane width, signed two's complement.
- NPOS, 49, spatial positions per frame (7x7).
- AW, 38, accumulator width (DW + 6).
- RECIP, 1337, reciprocal multiplier (approximately 65536/49).
- SHIFT, 16, right shift applied after the multiply.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- s_valid  in  1  input beat valid; no backpressure, every valid beat must be absorbed
- s_chan  in  7  channel group 0..63 ($clog2(64)+1 bits)
- s_last  in  1  final beat of the frame (row 6, col 6, chan 63)
- s_col  in  4  column 0..6 ($clog2(7)+1 bits)
- s_row  in  4  row 0..6
- s_data  in  256  8 lanes; lane k occupies bits [32k+31:32k]
- m_valid  out  1  pooled beat valid
- m_ready  in  1  downstream accept
- m_chan  out  7  channel group of the current output beat
- m_last  out  1  asserted on the m_chan==63 beat
- m_data  out  256  8 pooled lanes, same lane packing as s_data
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous and active-low, sampled on the clk rising edge.
- Values while reset is low: m_valid=0, m_chan=0, m_last=0, m_data=0, err=0, FSM=ACCUM, beat counter=0.
- Reset asserted mid-drain aborts the drain immediately; no further m_valid until the next frame completes.
- Storage: accumulator RAM with GROUPS entries x LANES x AW bits, indexed by s_chan.
- ACCUM state, on each s_valid beat:
  - If s_row==0 and s_col==0: acc[s_chan][k] = sign-extended s_data lane k (load, not add).
  - Otherwise: acc[s_chan][k] += sign-extended lane k.
  - Beat counter increments.
  - Back-to-back beats to the same s_chan must accumulate correctly; a read-after-write bypass is required.
- On the s_last beat:
  - That beat is accumulated first.
  - If the beat count including the s_last beat != GROUPS*NPOS (3136), set err.
  - Counter clears; FSM goes to DRAIN.
- DRAIN state:
  - Read acc[0..63] in order.
  - Per lane: avg = (acc * RECIP) >>> SHIFT. The multiply is signed AW-bit by unsigned 12-bit, the shift is arithmetic (floor), and the low DW bits are taken.
  - The result always fits in DW bits because RECIP*NPOS < 2^SHIFT; no saturation logic.
- Output handshake:
  - A beat transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_chan and m_last hold stable.
  - m_valid never drops without a transfer.
  - Beats are emitted in m_chan order 0..63, with m_last=1 only on m_chan==63.
- Latency:
  - First m_valid rises no later than 4 cycles after the s_last beat.
  - With m_ready held at 1, all 64 beats appear on 64 consecutive cycles.
  - The read/multiply pipeline stalls when the output register is full and not being accepted.
- After the m_last transfer the FSM returns to ACCUM. The next frame's beat may arrive in the same cycle as the m_last transfer and is accumulated normally.
- Any s_valid beat in DRAIN, other than one in the cycle of the m_last transfer, is dropped and sets err.
- err is sticky until reset. It does not suppress the drain: the frame is emitted with whatever was accumulated.
- s_chan > 63 or s_row/s_col > 6 on a valid beat: the beat is dropped and err is set.

Test Plan:
- Full frame, every lane = 100, m_ready=1 -> 64 beats, all lanes 99 (4900*1337>>16), m_last on chan 63, err=0, first m_valid within 4 cycles of s_last.
- Full frame, every lane = -100 -> all lanes -100 (floor of -99.96); lane k = k*1000 for chan 5 only (others 0) -> chan 5 lane k = floor(49000k*1337/65536), other chans 0.
- Two consecutive frames, second all 7 -> second output all 6 (343*1337>>16=6); no carry-over from frame 1, which confirms the load at position (0,0).
- m_ready toggled 1,0,0,1 pseudo-randomly during drain -> data held stable while stalled, exactly 64 transfers, chan order 0..63, no duplicates.
- s_last after only 3135 beats -> err=1 and the drain still emits 64 beats; an extra s_valid injected during DRAIN -> the beat is dropped, err stays 1, and the output values are unaffected.
- reset driven low at drain beat 20 -> m_valid=0 on the next cycle and err=0; a following clean frame produces the correct 64 beats.

Source files
------------

// File: rtl/ie_gap_head.sv
// Global average pooling head: accumulates a 7x7 x GROUPS x LANES frame per channel
// and drains one pooled beat per channel group through a valid/ready output.
module ie_gap_head #(
  parameter int GROUPS = 64,
  parameter int LANES  = 8,
  parameter int DW     = 32,
  parameter int NPOS   = 49,
  parameter int AW     = 38,
  parameter int RECIP  = 1337,
  parameter int SHIFT  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic [$clog2(GROUPS):0]    s_chan,
  input  logic                       s_last,
  input  logic [3:0]                 s_col,
  input  logic [3:0]                 s_row,
  input  logic [LANES*DW-1:0]        s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(GROUPS):0]    m_chan,
  output logic                       m_last,
  output logic [LANES*DW-1:0]        m_data,
  output logic                       err
);

  localparam int CW   = $clog2(GROUPS);
  localparam int RW   = 12;
  localparam int CNTW = $clog2(GROUPS*NPOS+1);
  localparam int PW   = AW + RW + 1;

  localparam logic [CW:0]     CHAN_MAX    = (CW+1)'(GROUPS-1);
  localparam logic [CW-1:0]   LAST_CHAN   = CW'(GROUPS-1);
  localparam logic [3:0]      POS_MAX     = 4'd6;
  localparam logic [CNTW-1:0] FRAME_BEATS = CNTW'(GROUPS*NPOS);
  localparam logic [RW-1:0]   RECIP_U     = RW'(RECIP);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t state, state_nxt;

  function automatic logic signed [AW-1:0] sext(input logic [DW-1:0] x);
    return {{(AW-DW){x[DW-1]}}, x};
  endfunction

  // Signed accumulator times unsigned reciprocal, then floor shift; fits DW by construction.
  function automatic logic [DW-1:0] avg_lane(input logic signed [AW-1:0] a);
    logic signed [PW-1:0] prod;
    prod = PW'(a) * PW'($signed({1'b0, RECIP_U}));
    return DW'(prod >>> SHIFT);
  endfunction

  logic [LANES*AW-1:0] acc_mem [GROUPS];

  logic [CNTW-1:0]      cnt;
  logic [CW:0]          rd_idx;
  logic                 beat_ok, accept, drop, last_xfer, out_adv, rd_go;
  logic [LANES*AW-1:0]  beat_rd, drn_rd, sum_p0;
  logic [LANES*DW-1:0]  avg_vec;

  logic                 vld_p0, load_p0;
  logic [CW-1:0]        chan_p0;
  logic [LANES*DW-1:0]  dat_p0;
  logic [LANES*AW-1:0]  rd_p0;

  logic                 vld_p1;
  logic [CW-1:0]        chan_p1;
  logic [LANES*AW-1:0]  acc_p1;

  assign beat_ok   = s_valid && (s_chan <= CHAN_MAX) && (s_row <= POS_MAX) && (s_col <= POS_MAX);
  assign last_xfer = m_valid && m_ready && m_last;
  assign accept    = beat_ok && ((state == ACCUM) || last_xfer);
  assign drop      = s_valid && !accept;
  assign out_adv   = !m_valid || m_ready;
  assign rd_go     = (state == DRAIN) && !rd_idx[CW] && (!vld_p1 || out_adv);

  // The write of the beat held in p0 lands one cycle late, so both read ports forward it.
  assign beat_rd = (vld_p0 && chan_p0 == s_chan[CW-1:0]) ? sum_p0 : acc_mem[s_chan[CW-1:0]];
  assign drn_rd  = (vld_p0 && chan_p0 == rd_idx[CW-1:0]) ? sum_p0 : acc_mem[rd_idx[CW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && s_last) state_nxt = DRAIN;
      DRAIN: if (last_xfer && !(accept && s_last)) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      err    <= 1'b0;
      rd_idx <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) cnt <= s_last ? '0 : cnt + 1'b1;
      if (drop || (accept && s_last && (cnt + 1'b1) != FRAME_BEATS)) err <= 1'b1;
      if (accept && s_last) rd_idx <= '0;
      else if (rd_go)       rd_idx <= rd_idx + 1'b1;
      if (rd_go)        vld_p1 <= 1'b1;
      else if (out_adv) vld_p1 <= 1'b0;
    end
  end

  // p0: captured beat plus its (forwarded) accumulator read
  always_ff @(posedge clk) begin
    if (accept) begin
      chan_p0 <= s_chan[CW-1:0];
      load_p0 <= (s_row == 4'd0) && (s_col == 4'd0);
      dat_p0  <= s_data;
      rd_p0   <= beat_rd;
    end
  end

  always_comb begin
    sum_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      if (load_p0) sum_p0[k*AW +: AW] = sext(dat_p0[k*DW +: DW]);
      else         sum_p0[k*AW +: AW] = rd_p0[k*AW +: AW] + sext(dat_p0[k*DW +: DW]);
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) acc_mem[chan_p0] <= sum_p0;
  end

  // p1: drain read of one accumulator entry
  always_ff @(posedge clk) begin
    if (rd_go) begin
      chan_p1 <= rd_idx[CW-1:0];
      acc_p1  <= drn_rd;
    end
  end

  always_comb begin
    avg_vec = '0;
    for (int k = 0; k < LANES; k++) avg_vec[k*DW +: DW] = avg_lane(acc_p1[k*AW +: AW]);
  end

  // output register: loads only when empty or being accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_chan  <= '0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (vld_p1 && out_adv) begin
      m_valid <= 1'b1;
      m_chan  <= {1'b0, chan_p1};
      m_last  <= (chan_p1 == LAST_CHAN);
      m_data  <= avg_vec;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ie_gap_head.sv
// Bench for ie_gap_head: directed frame sequence with random lane data, checked
// against per-channel frame sums and floor-divided reciprocal averages.
module tb_ie_gap_head;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic [6:0]   s_chan;
  logic         s_last;
  logic [3:0]   s_col;
  logic [3:0]   s_row;
  logic [255:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [6:0]   m_chan;
  logic         m_last;
  logic [255:0] m_data;
  logic         err;

  int tests = 0;
  int fails = 0;
  longint exp_sum [64][8];

  ie_gap_head dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_chan(s_chan), .s_last(s_last), .s_col(s_col), .s_row(s_row),
    .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_last(m_last), .m_data(m_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Pooled value: floor(sum * 1337 / 65536)
  function automatic logic [255:0] exp_vec(input int ch);
    logic [255:0] v;
    longint p, q;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      p = exp_sum[ch][k] * 64'sd1337;
      q = p / 64'sd65536;
      if (p < 0 && q * 64'sd65536 != p) q = q - 1;
      v[k*32 +: 32] = q[31:0];
    end
    return v;
  endfunction

  function automatic logic [31:0] lane_val(input int mode, input int cval, input int ch, input int k);
    case (mode)
      0:       return 32'(cval);
      1:       return (ch == 5) ? 32'(k * 1000) : 32'd0;
      default: return $urandom();
    endcase
  endfunction

  task automatic beat(input logic [6:0] ch, input logic [3:0] r, input logic [3:0] c,
                      input logic last, input logic [255:0] d);
    s_valid = 1'b1; s_chan = ch; s_row = r; s_col = c; s_last = last; s_data = d;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int mode, input int cval, input bit chan_outer,
                            input bit short_f, input bit bad);
    logic [255:0] d;
    logic [31:0]  v;
    int ch, p;
    for (int a = 0; a < 64; a++)
      for (int k = 0; k < 8; k++) exp_sum[a][k] = 0;
    for (int i = 0; i < 3136; i++) begin
      if (chan_outer) begin ch = i / 49; p = i % 49; end
      else            begin ch = i % 64; p = i / 64; end
      if (bad && i == 1000) beat(7'd70, 4'd1, 4'd1, 1'b0, {8{32'h12345678}});
      if (bad && i == 2000) beat(7'd3, 4'd7, 4'd0, 1'b0, {8{32'h0badf00d}});
      if (!(short_f && i == 3134)) begin
        d = '0;
        for (int k = 0; k < 8; k++) begin
          v = lane_val(mode, cval, ch, k);
          d[k*32 +: 32] = v;
          exp_sum[ch][k] += longint'($signed(v));
        end
        beat(7'(ch), 4'(p / 7), 4'(p % 7), i == 3135, d);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // rmode 0: m_ready held high; rmode 1: random m_ready. abort_at >= 0 resets after that many beats.
  task automatic collect(input int rmode, input int abort_at, input bit inject);
    int n = 0, cyc = 0, first = -1, tfirst = -1, tlast = -1;
    bit pend = 0;
    logic [255:0] hd;
    logic [6:0]   hc;
    logic         rdy;
    hd = '0; hc = '0;
    while (n < 64 && cyc < 2000) begin
      if (pend) begin
        chki("hold_vld", int'(m_valid), 1);
        chk("hold_data", m_data, hd);
        chki("hold_chan", int'(m_chan), int'(hc));
      end
      if (m_valid && first < 0) first = cyc;
      if (abort_at >= 0 && n == abort_at) begin
        reset = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        chki("rst_vld", int'(m_valid), 0);
        chki("rst_err", int'(err), 0);
        chk("rst_data", m_data, '0);
        reset = 1'b1;
        for (int j = 0; j < 8; j++) begin
          @(posedge clk); #1;
          chki("rst_quiet", int'(m_valid), 0);
        end
        return;
      end
      rdy = (rmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      m_ready = rdy;
      if (inject && cyc == 5) begin
        s_valid = 1'b1; s_chan = 7'd3; s_row = 4'd2; s_col = 4'd2; s_last = 1'b0;
        s_data = {8{32'h7fff0000}};
      end else begin
        s_valid = 1'b0;
      end
      pend = m_valid && !rdy;
      hd = m_data;
      hc = m_chan;
      if (m_valid && rdy) begin
        chki("chan", int'(m_chan), n);
        chki("last", int'(m_last), int'(n == 63));
        chk("data", m_data, exp_vec(n));
        if (tfirst < 0) tfirst = cyc;
        tlast = cyc;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chki("beats", n, 64);
    chki("latency", int'(first >= 0 && first <= 4), 1);
    if (rmode == 0) chki("burst", tlast - tfirst, 63);
    chki("no_extra", int'(m_valid), 0);
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_chan = '0; s_row = '0; s_col = '0; s_last = 1'b0;
    s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chki("rst_m_valid", int'(m_valid), 0);
    chki("rst_m_chan", int'(m_chan), 0);
    chki("rst_m_last", int'(m_last), 0);
    chki("rst_err0", int'(err), 0);
    chk("rst_m_data", m_data, '0);
    reset = 1'b1;
    @(posedge clk); #1;

    send_frame(0, 100, 0, 0, 0);   collect(0, -1, 0); chki("err_pos100", int'(err), 0);
    send_frame(0, -100, 1, 0, 0);  collect(0, -1, 0); chki("err_neg100", int'(err), 0);
    send_frame(1, 0, 0, 0, 0);     collect(0, -1, 0); chki("err_chan5", int'(err), 0);
    send_frame(2, 0, 1, 0, 0);     collect(1, -1, 0); chki("err_rand", int'(err), 0);
    send_frame(0, 7, 0, 0, 0);     collect(0, -1, 0); chki("err_seven", int'(err), 0);
    send_frame(0, 100, 0, 1, 0);   collect(0, -1, 1); chki("err_short", int'(err), 1);
    send_frame(2, 0, 0, 0, 0);     collect(0, 20, 0);
    send_frame(2, 0, 0, 0, 0);     collect(1, -1, 0); chki("err_clean", int'(err), 0);
    send_frame(2, 0, 1, 0, 1);     collect(0, -1, 0); chki("err_badbeat", int'(err), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
